// File: rtl/cmac_tx_store_fwd_fifo.sv
// cmac_tx_store_fwd_fifo: store-and-forward packet buffer from ERNIC to CMAC tx; packets it cannot hold are dropped whole
module cmac_tx_store_fwd_fifo #(
  parameter int DATA_W        = 512,
  parameter int ADDR_W        = 9,
  parameter int MAX_PKT_BEATS = 250,
  parameter int CNT_W         = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic [DATA_W/8-1:0] s_axis_tkeep,
  input  logic                s_axis_tvalid,
  input  logic                s_axis_tlast,
  input  logic                m_axis_tready,
  output logic                m_axis_tvalid,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic [DATA_W/8-1:0] m_axis_tkeep,
  output logic                m_axis_tlast,
  output logic                m_axis_tuser,
  output logic [ADDR_W:0]     pkts_stored,
  output logic [ADDR_W:0]     fifo_level,
  output logic [CNT_W-1:0]    pkt_fwd_cnt,
  output logic [CNT_W-1:0]    pkt_drop_cnt,
  output logic                drop_pulse
);
  localparam int KEEP_W = DATA_W / 8;
  localparam int ENT_W  = DATA_W + KEEP_W + 1;
  localparam int BC_W   = $clog2(MAX_PKT_BEATS + 1);
  localparam logic [ADDR_W:0] P1 = 1;
  localparam logic [CNT_W-1:0] C1 = 1;
  typedef enum logic [1:0] {IDLE, PKT, DROP} wr_state_e;
  wr_state_e state_q, state_d;
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, fetch_ptr_q, fetch_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0] pkts_q, pkts_d, used;
  logic [BC_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0] fwd_q, fwd_d, drop_cnt_q, drop_cnt_d;
  logic drop_pulse_q, pend_q, pend_d;
  logic [1:0] cnt_q, cnt_d;
  logic [2:0] occ;
  logic [ENT_W-1:0] mem [2**ADDR_W];
  logic [ENT_W-1:0] ram_q, out0_q, out0_d, out1_q, out1_d;
  logic room, wr_en, drop, commit, pop, fetch, last_hs;
  // rd_ptr only advances on delivery, so beats parked in the read pipe still occupy buffer space
  always_comb begin
    used = wr_ptr_q - rd_ptr_q;
    room = !used[ADDR_W] && beat_cnt_q < BC_W'(MAX_PKT_BEATS);
    wr_en = s_axis_tvalid && state_q != DROP && room;
    drop = s_axis_tvalid && state_q != DROP && !room;
    commit = wr_en && s_axis_tlast;
    state_d = !s_axis_tvalid ? state_q : s_axis_tlast ? IDLE : (state_q == DROP || drop) ? DROP : PKT;
    wr_ptr_d = drop ? commit_ptr_q : wr_en ? wr_ptr_q + P1 : wr_ptr_q;
    commit_ptr_d = commit ? wr_ptr_q + P1 : commit_ptr_q;
    beat_cnt_d = (s_axis_tvalid && s_axis_tlast) || drop ? '0 : wr_en ? beat_cnt_q + BC_W'(1) : beat_cnt_q;
    drop_cnt_d = drop && !(&drop_cnt_q) ? drop_cnt_q + C1 : drop_cnt_q;
    pop = cnt_q != 2'd0 && m_axis_tready;
    last_hs = pop && out0_q[ENT_W-1];
    occ = {1'b0, cnt_q} + {2'b0, pend_q} - {2'b0, pop};
    fetch = fetch_ptr_q != commit_ptr_q && occ < 3'd2;
    pend_d = fetch;
    fetch_ptr_d = fetch ? fetch_ptr_q + P1 : fetch_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + P1 : rd_ptr_q;
    cnt_d = cnt_q + {1'b0, pend_q} - {1'b0, pop};
    out0_d = pop && cnt_q == 2'd2 ? out1_q : pend_q && (pop || cnt_q == 2'd0) ? ram_q : out0_q;
    out1_d = pend_q && !pop && cnt_q == 2'd1 ? ram_q : out1_q;
    pkts_d = pkts_q + (commit ? P1 : '0) - (last_hs ? P1 : '0);
    fwd_d = last_hs && !(&fwd_q) ? fwd_q + C1 : fwd_q;
  end
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[ADDR_W-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    if (fetch) ram_q <= mem[fetch_ptr_q[ADDR_W-1:0]];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      commit_ptr_q <= '0;
      fetch_ptr_q <= '0;
      rd_ptr_q <= '0;
      pkts_q <= '0;
      beat_cnt_q <= '0;
      fwd_q <= '0;
      drop_cnt_q <= '0;
      drop_pulse_q <= 1'b0;
      pend_q <= 1'b0;
      cnt_q <= '0;
      out0_q <= '0;
      out1_q <= '0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      fetch_ptr_q <= fetch_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      pkts_q <= pkts_d;
      beat_cnt_q <= beat_cnt_d;
      fwd_q <= fwd_d;
      drop_cnt_q <= drop_cnt_d;
      drop_pulse_q <= drop;
      pend_q <= pend_d;
      cnt_q <= cnt_d;
      out0_q <= out0_d;
      out1_q <= out1_d;
    end
  end
  assign m_axis_tvalid = cnt_q != 2'd0;
  assign m_axis_tdata  = out0_q[DATA_W-1:0];
  assign m_axis_tkeep  = out0_q[DATA_W +: KEEP_W];
  assign m_axis_tlast  = out0_q[ENT_W-1];
  assign m_axis_tuser  = 1'b0;
  assign pkts_stored   = pkts_q;
  assign fifo_level    = wr_ptr_q - rd_ptr_q;
  assign pkt_fwd_cnt   = fwd_q;
  assign pkt_drop_cnt  = drop_cnt_q;
  assign drop_pulse    = drop_pulse_q;
endmodule
